// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared CPU constants for the iterative divider (state encodings,
// iteration count, divide-by-zero quotient).
`default_nettype none

package div_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    localparam int unsigned c_DIV_ITERS     = 32;
    localparam logic [5:0]  c_ITER_LAST     = 6'(c_DIV_ITERS - 1);
    localparam logic [31:0] c_DIV_ZERO_QUO  = 32'hFFFF_FFFF;

endpackage : div_unit_pkg

`default_nettype wire

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the control unit and the divider.
`default_nettype none

interface div_unit_if;
    logic        start;
    logic        is_unsigned;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start, is_unsigned, A, B,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, is_unsigned, A, B,
        output quotient, remainder, busy, done, div_zero
    );
endinterface : div_unit_if

`default_nettype wire

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration.
// Revision: 1.0
`default_nettype none

module div_step (
    input  wire logic [32:0] i_rem,
    input  wire logic [31:0] i_quo,
    input  wire logic [31:0] i_div,
    output logic      [32:0] o_rem,
    output logic      [31:0] o_quo
);

    logic [32:0] w_shifted;
    logic [32:0] w_diff;

    // The quotient register doubles as the dividend shift source.
    assign w_shifted = {i_rem[31:0], i_quo[31]};
    assign w_diff    = w_shifted - {1'b0, i_div};

    always_comb begin
        o_rem = w_shifted;
        o_quo = {i_quo[30:0], 1'b0};
        if (!w_diff[32]) begin
            o_rem = w_diff;
            o_quo = {i_quo[30:0], 1'b1};
        end
    end

endmodule : div_step

`default_nettype wire

// File: rtl/div_unit.sv
// div_unit: 32-bit signed/unsigned restoring divider, 34-cycle latency.
// Optional macro DIV_UNSIGNED_EN enables DIVU semantics via is_unsigned.
`default_nettype none

module div_unit
    import div_unit_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  reset,
    div_unit_if.slave  bus
);

    div_state_t  r_state;
    logic [5:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_zero;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;
    logic        r_busy;
    logic        r_done;
    logic        r_div_zero;

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_step_rem;
    logic [31:0] w_step_quo;

`ifdef DIV_UNSIGNED_EN
    assign w_signed = ~bus.is_unsigned;
`else
    logic w_unused_is_unsigned;
    assign w_unused_is_unsigned = bus.is_unsigned;
    assign w_signed = 1'b1;
`endif

    assign w_a_neg = w_signed & bus.A[31];
    assign w_b_neg = w_signed & bus.B[31];
    assign w_a_mag = w_a_neg ? (~bus.A + 32'd1) : bus.A;
    assign w_b_mag = w_b_neg ? (~bus.B + 32'd1) : bus.B;

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 6'd0;
            r_rem       <= 33'd0;
            r_quo       <= 32'd0;
            r_div       <= 32'd0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_zero      <= 1'b0;
            r_quotient  <= 32'd0;
            r_remainder <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_div_zero <= 1'b0;
                        r_busy     <= 1'b1;
                        r_cnt      <= 6'd0;
                        r_div      <= w_b_mag;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        // Zero divisor bypasses the datapath with fixed results.
                        if (bus.B == 32'd0) begin
                            r_zero  <= 1'b1;
                            r_quo   <= c_DIV_ZERO_QUO;
                            r_rem   <= {1'b0, bus.A};
                            r_state <= ST_DONE;
                        end else begin
                            r_zero  <= 1'b0;
                            r_quo   <= w_a_mag;
                            r_rem   <= 33'd0;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_ITER_LAST) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (r_neg_q) begin
                        r_quo <= ~r_quo + 32'd1;
                    end
                    if (r_neg_r) begin
                        r_rem <= {1'b0, ~r_rem[31:0] + 32'd1};
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_quotient  <= r_quo;
                    r_remainder <= r_rem[31:0];
                    r_div_zero  <= r_zero;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.div_zero  = r_div_zero;

endmodule : div_unit

`default_nettype wire
